// File: rtl/kan_pkg.sv
// Shared constants and sizing helpers for the KAN replay FIFO slice.
package kan_pkg;

   // Default lane width; each stored entry is NCH lanes of LANE_W bits.
   localparam int unsigned DWIDTH_DEF = 32'd16;
   localparam int unsigned LANE_W     = DWIDTH_DEF;

   // Default depth exponent and lane count.
   localparam int unsigned NDEPTH_DEF = 32'd4;
   localparam int unsigned NCH_DEF    = 32'd1;

   // Lane slicing width for a given per-lane data width.
   function automatic int unsigned lane_w(input int unsigned dwidth);
      return dwidth;
   endfunction

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   function automatic int unsigned ptr_w(input int unsigned ndepth);
      return ndepth + 32'd1;
   endfunction

endpackage

// File: rtl/kan_fifo_ram.sv
// Simple dual-port storage for the replay FIFO: synchronous write and a
// registered read port with enable. The array itself is never reset; only
// the read-data register is cleared by reset.
module kan_fifo_ram #(
   parameter int unsigned AW = 32'd4,
   parameter int unsigned W  = 32'd16
) (
   input  logic          iclk,
   input  logic          iresetn,
   input  logic          iwe,
   input  logic [AW-1:0] iwaddr,
   input  logic [W-1:0]  iwdata,
   input  logic          ire,
   input  logic [AW-1:0] iraddr,
   output logic [W-1:0]  ordata
);

   logic [W-1:0] mem_r [0:(2**AW)-1];
   logic [W-1:0] rdata_r;

   // Store write data at the write address.
   always_ff @(posedge iclk) begin
      if (iwe) begin
         mem_r[iwaddr] <= iwdata;
      end
   end

   // Registered read; data holds when no read is enabled.
   always_ff @(posedge iclk) begin
      if (!iresetn) begin
         rdata_r <= '0;
      end else if (ire) begin
         rdata_r <= mem_r[iraddr];
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign ordata = rdata_r;

endmodule

// File: rtl/kan_replay_fifo.sv
// Multi-lane FIFO with a retained replay window. A mark pointer protects
// already-read entries so a pass can be replayed by rewinding the read
// pointer. Status outputs are registered from next-state pointers, so they
// always equal the documented functions of the current pointers.
module kan_replay_fifo
   import kan_pkg::*;
#(
   parameter int unsigned DWIDTH = DWIDTH_DEF,
   parameter int unsigned NDEPTH = NDEPTH_DEF,
   parameter int unsigned NCH    = NCH_DEF
) (
   input  logic                     iclk,
   input  logic                     iresetn,
   input  logic                     iclr,
   input  logic                     iwrite,
   input  logic [NCH*DWIDTH-1:0]    idata,
   output logic                     ofull,
   input  logic                     iread,
   output logic [NCH*DWIDTH-1:0]    odata,
   output logic                     ovalid,
   output logic                     oempty,
   output logic [NDEPTH:0]          ocount,
   input  logic                     ikeep,
   input  logic                     imark,
   input  logic                     irewind,
   output logic                     oovf
);

   localparam int unsigned W    = NCH * lane_w(DWIDTH);
   localparam int unsigned PTRW = ptr_w(NDEPTH);
   localparam logic [PTRW-1:0] DEPTH_V = {1'b1, {NDEPTH{1'b0}}};
   localparam logic [PTRW-1:0] PTR_ONE = {{(PTRW-1){1'b0}}, 1'b1};

   logic [PTRW-1:0] wptr_r, rptr_r, mptr_r;
   logic [PTRW-1:0] wptr_nxt_s, rptr_nxt_s, mptr_nxt_s;
   logic            empty_r, full_r, ovalid_r, ovf_r;
   logic [PTRW-1:0] count_r;
   logic            wr_grant_s, rd_grant_s;
   logic            ram_we_s, ram_re_s;
   logic [W-1:0]    ram_rdata_s;

   // Grants from pre-edge flags and next-state pointer computation.
   always_comb begin
      wr_grant_s = iwrite & ~full_r;
      rd_grant_s = iread & ~empty_r & ~irewind;

      if (wr_grant_s) begin
         wptr_nxt_s = wptr_r + PTR_ONE;
      end else begin
         wptr_nxt_s = wptr_r;
      end

      if (irewind) begin
         rptr_nxt_s = mptr_r;
      end else if (rd_grant_s) begin
         rptr_nxt_s = rptr_r + PTR_ONE;
      end else begin
         rptr_nxt_s = rptr_r;
      end

      // Rewind together with mark keeps the existing mark.
      if (irewind & imark) begin
         mptr_nxt_s = mptr_r;
      end else if (~ikeep | imark) begin
         mptr_nxt_s = rptr_nxt_s;
      end else begin
         mptr_nxt_s = mptr_r;
      end
   end

   // Pointer, flag and strobe registers with reset > clear > normal priority.
   always_ff @(posedge iclk) begin
      if (!iresetn) begin
         wptr_r   <= '0;
         rptr_r   <= '0;
         mptr_r   <= '0;
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
         count_r  <= '0;
         ovalid_r <= 1'b0;
         ovf_r    <= 1'b0;
      end else if (iclr) begin
         wptr_r   <= '0;
         rptr_r   <= '0;
         mptr_r   <= '0;
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
         count_r  <= '0;
         ovalid_r <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         wptr_r   <= wptr_nxt_s;
         rptr_r   <= rptr_nxt_s;
         mptr_r   <= mptr_nxt_s;
         empty_r  <= (rptr_nxt_s == wptr_nxt_s);
         full_r   <= ((wptr_nxt_s - mptr_nxt_s) == DEPTH_V);
         count_r  <= wptr_nxt_s - rptr_nxt_s;
         ovalid_r <= rd_grant_s;
         ovf_r    <= ovf_r | (iwrite & full_r);
      end
   end

   // A clear discards any same-cycle write or read so odata holds.
   assign ram_we_s = wr_grant_s & iresetn & ~iclr;
   assign ram_re_s = rd_grant_s & ~iclr;

   kan_fifo_ram #(
      .AW (NDEPTH),
      .W  (W)
   ) u_ram (
      .iclk    (iclk),
      .iresetn (iresetn),
      .iwe     (ram_we_s),
      .iwaddr  (wptr_r[NDEPTH-1:0]),
      .iwdata  (idata),
      .ire     (ram_re_s),
      .iraddr  (rptr_r[NDEPTH-1:0]),
      .ordata  (ram_rdata_s)
   );

   assign odata  = ram_rdata_s;
   assign ovalid = ovalid_r;
   assign oempty = empty_r;
   assign ofull  = full_r;
   assign ocount = count_r;
   assign oovf   = ovf_r;

endmodule

// File: tb/tb_kan_replay_fifo.sv
// Self-checking bench for kan_replay_fifo (NCH=2, NDEPTH=2, DWIDTH=16).
// Reference model: a queue of retained entries plus a read index into it.
module tb_kan_replay_fifo;

   localparam int DWIDTH = 16;
   localparam int NDEPTH = 2;
   localparam int NCH    = 2;
   localparam int W      = NCH * DWIDTH;
   localparam int DEPTH  = 1 << NDEPTH;

   logic            iclk = 1'b0;
   logic            iresetn, iclr, iwrite, iread, ikeep, imark, irewind;
   logic [W-1:0]    idata;
   logic            ofull, ovalid, oempty, oovf;
   logic [W-1:0]    odata;
   logic [NDEPTH:0] ocount;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: q holds entries from the mark up to the write point,
   // rd_idx is how many of them have been read since the mark.
   logic [W-1:0] q[$];
   int           rd_idx;
   logic [W-1:0] m_odata;
   logic         m_ovalid, m_ovf;

   kan_replay_fifo #(.DWIDTH(DWIDTH), .NDEPTH(NDEPTH), .NCH(NCH)) dut (
      .iclk(iclk), .iresetn(iresetn), .iclr(iclr), .iwrite(iwrite), .idata(idata),
      .ofull(ofull), .iread(iread), .odata(odata), .ovalid(ovalid), .oempty(oempty),
      .ocount(ocount), .ikeep(ikeep), .imark(imark), .irewind(irewind), .oovf(oovf)
   );

   always #5 iclk = ~iclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic full_pre, wr_ok, rd_ok;
      if (!iresetn) begin
         q.delete(); rd_idx = 0; m_odata = '0; m_ovalid = 1'b0; m_ovf = 1'b0;
      end else if (iclr) begin
         q.delete(); rd_idx = 0; m_ovalid = 1'b0; m_ovf = 1'b0;
      end else begin
         full_pre = (q.size() == DEPTH);
         wr_ok    = iwrite && !full_pre;
         rd_ok    = iread && (rd_idx < q.size()) && !irewind;
         if (iwrite && full_pre) m_ovf = 1'b1;
         m_ovalid = rd_ok;
         if (rd_ok) begin
            m_odata = q[rd_idx];
            rd_idx++;
         end
         if (irewind) rd_idx = 0;
         if (!(irewind && imark) && (!ikeep || imark)) begin
            repeat (rd_idx) void'(q.pop_front());
            rd_idx = 0;
         end
         if (wr_ok) q.push_back(idata);
      end
   endtask

   task automatic check_all();
      chk("odata",  odata, m_odata);
      chk("ovalid", 32'(ovalid), 32'(m_ovalid));
      chk("oempty", 32'(oempty), 32'(rd_idx == q.size()));
      chk("ofull",  32'(ofull),  32'(q.size() == DEPTH));
      chk("ocount", 32'(ocount), 32'(q.size() - rd_idx));
      chk("oovf",   32'(oovf),   32'(m_ovf));
   endtask

   task automatic tick(input logic w, input logic [W-1:0] d, input logic r,
                       input logic k, input logic m, input logic rw, input logic c);
      iwrite = w; idata = d; iread = r; ikeep = k; imark = m; irewind = rw; iclr = c;
      @(posedge iclk);
      model_step();
      #1;
      check_all();
   endtask

   logic [W-1:0] v [0:7];
   logic [W-1:0] held;
   logic         k_rand;

   initial begin
      for (int i = 0; i < 8; i++) v[i] = {16'(2*i+1), 16'(2*i+2)};
      iresetn = 1'b0; iclr = 1'b0; iwrite = 1'b0; iread = 1'b0; ikeep = 1'b0;
      imark = 1'b0; irewind = 1'b0; idata = '0;
      q.delete(); rd_idx = 0; m_odata = '0; m_ovalid = 1'b0; m_ovf = 1'b0;

      // Reset state
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_odata", odata, 32'h0);
      chk("rst_oempty", 32'(oempty), 32'd1);
      chk("rst_ocount", 32'(ocount), 32'd0);
      iresetn = 1'b1;

      // Fill/drain
      for (int i = 0; i < 4; i++) tick(1'b1, v[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("fill_full", 32'(ofull), 32'd1);
      chk("fill_count", 32'(ocount), 32'd4);
      tick(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("fill_ovf", 32'(oovf), 32'd1);
      chk("fill_ovf_count", 32'(ocount), 32'd4);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("drain_data", odata, 32'h0001_0002 + 32'h0002_0002 * 32'(i));
         chk("drain_valid", 32'(ovalid), 32'd1);
      end
      chk("drain_empty", 32'(oempty), 32'd1);

      // Replay
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tick(1'b1, v[i+4], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("replay_count", 32'(ocount), 32'd3);
      for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("replay_full", 32'(ofull), 32'd0);
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("replay_rew_count", 32'(ocount), 32'd3);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         chk("replay_data", odata, v[i+4]);
      end

      // Mark move
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, v[i], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mark_full_before", 32'(ofull), 32'd1);
      tick(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("mark_full_after", 32'(ofull), 32'd0);
      tick(1'b1, v[4], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, v[5], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mark_ovf_clear", 32'(oovf), 32'd0);
      tick(1'b1, v[6], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mark_ovf_set", 32'(oovf), 32'd1);
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mark_reread", odata, v[2]);

      // Simultaneous events
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, v[7], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sim_empty_valid", 32'(ovalid), 32'd0);
      tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sim_empty_data", odata, v[7]);
      tick(1'b1, v[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, v[1], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, v[2], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sim_rw_count", 32'(ocount), 32'd2);
      tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("sim_rew_valid", 32'(ovalid), 32'd0);
      chk("sim_rew_count", 32'(ocount), 32'd2);

      // Pointer wrap, back-to-back
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 32'(32'h5000), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 3*DEPTH; i++) begin
         tick(1'b1, 32'h5000 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("wrap_data", odata, 32'h5000 + 32'(i-1));
      end
      tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("wrap_last", odata, 32'h5000 + 32'(3*DEPTH));
      chk("wrap_ovf", 32'(oovf), 32'd0);

      // Randomized traffic against the model
      k_rand = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 31) == 0) k_rand = ~k_rand;
         tick(1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 9) < 6),
              k_rand, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 11) == 0),
              1'($urandom_range(0, 199) == 0));
      end

      // Clear mid-operation with ocount = 3 and a same-cycle read
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, v[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, v[4], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      held = v[0];
      chk("clr_pre_count", 32'(ocount), 32'd3);
      tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("clr_empty", 32'(oempty), 32'd1);
      chk("clr_count", 32'(ocount), 32'd0);
      chk("clr_ovf", 32'(oovf), 32'd0);
      chk("clr_odata_held", odata, held);

      // Reset mid-operation
      tick(1'b1, v[5], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      iresetn = 1'b0;
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_odata", odata, 32'h0);
      chk("rst_mid_empty", 32'(oempty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/kan_replay_fifo.md
# kan_replay_fifo

Parametrised multi-lane FIFO with a retained replay window, used between the coefficient/activation loaders and the KAN spline evaluators. Up to NCH lanes of DWIDTH-bit data move in lockstep under one set of pointers. A mark pointer protects already-read entries, so a pass can be replayed with a rewind instead of being reloaded. It also provides full/empty/occupancy status, a registered read port with a valid strobe, and a sticky overflow flag.

## Interface
- DWIDTH, 16, bits per lane
- NDEPTH, 4, log2 of depth; DEPTH = 2^NDEPTH entries
- NCH, 1, lanes stored per entry; entry width W = NCH*DWIDTH
- iclk  in  1  clock; all logic on rising edge
- iresetn  in  1  synchronous, active-low reset
- iclr  in  1  synchronous clear of pointers and flags; data RAM untouched
- iwrite  in  1  write request
- idata  in  W  write data; lane k occupies bits [k*DWIDTH +: DWIDTH]
- ofull  out  1  no free entry; a write would overflow
- iread  in  1  read request
- odata  out  W  registered read data
- ovalid  out  1  odata updated this cycle by a granted read
- oempty  out  1  no unread entry
- ocount  out  NDEPTH+1  unread entries (wptr - rptr)
- ikeep  in  1  1 = freeze mark (replay mode); 0 = mark tracks read pointer (plain FIFO)
- imark  in  1  in replay mode, move the mark to the next read position
- irewind  in  1  reload the read pointer from the mark
- oovf  out  1  sticky; set by a write attempted while full

## Operation
- Pointers wptr, rptr and mptr are each NDEPTH+1 bits and wrap modulo 2^(NDEPTH+1). Entry address is ptr[NDEPTH-1:0].
- oempty = (rptr == wptr). ofull = (wptr - mptr == DEPTH). ocount = wptr - rptr.
- Entries between mptr and wptr are retained. Reads do not free space unless the mark follows rptr.
- Write is granted when iwrite & ~ofull. It stores idata at wptr and increments wptr.
- A write while full is dropped, sets oovf and leaves the pointers unchanged.
- Read is granted when iread & ~oempty & ~irewind. odata <= mem[rptr], ovalid <= 1 and rptr increments.
- A read while empty is a no-op: ovalid = 0 and odata holds.
- Rewind (irewind): rptr <= mptr. The rewind takes priority over a same-cycle read, and ovalid = 0 that cycle.
- Mark update: mptr <= rptr_next when ~ikeep or imark. rptr_next is the rptr value after this cycle's read or rewind.
- If irewind and imark are asserted together, the mark is unchanged.
- When ikeep falls, the mark snaps to rptr_next on that edge, freeing the replay window.
- Flags are computed from pre-edge pointers. A same-cycle write does not make a read grantable.
- A same-cycle read never frees space for a write.
- Priority: iresetn low > iclr > the rules above.
- iresetn low or iclr: wptr = rptr = mptr = 0, ovalid = 0, oovf = 0. Reset also zeroes odata; iclr leaves odata held.

## Timing
- Reset values: odata 0, ovalid 0, oempty 1, ofull 0, ocount 0, oovf 0.
- Read latency is 1 cycle: a read granted at edge N gives valid odata and ovalid high after edge N. ovalid is a single-cycle strobe per grant.
- Write-to-read latency: data written at edge N is readable by a request at edge N+1, since oempty deasserts after edge N.
- oempty, ofull, ocount and oovf are registered-pointer functions and update the cycle after the causing edge.
- Reset or iclr asserted mid-stream takes effect at that edge. A read granted the same cycle is discarded.
- Full throughput is one write and one read per cycle, sustained.

## Structure
- Shared package kan_pkg holds:
  - the lane-slicing helper constant LANE_W = DWIDTH;
  - the pointer-width rule PTRW = NDEPTH+1.
- Sub-module kan_fifo_ram:
  - simple dual-port, DEPTH x W;
  - synchronous write, registered read with read enable;
  - no reset on the array.
- Top level holds the pointers, flags and grant logic only.

## Test plan
- Fill/drain, NCH=2, NDEPTH=2: write 4 entries 0x0001_0002..0x0007_0008.
  - ofull = 1 and ocount = 4.
  - 5th write sets oovf with no pointer change.
  - 4 reads return the entries in order with ovalid each cycle, then oempty = 1.
- Replay: ikeep = 1, write A,B,C, read 3, then irewind.
  - ocount = 3.
  - Re-read returns A,B,C.
  - ofull is never affected by reads.
- Mark move: ikeep = 1, write 4 (DEPTH = 4), read 2, pulse imark.
  - ofull drops to 0.
  - Two more writes are accepted, the third sets oovf.
  - irewind re-reads from entry 2.
- Simultaneous events:
  - Read+write on empty: no ovalid that cycle, data out next.
  - Read+write at ocount = 2: ocount stays 2.
  - irewind+iread: no ovalid, rptr = mptr.
- Pointer wrap: ikeep = 0, stream 3*DEPTH writes/reads back-to-back at one per cycle; sequence intact, oovf = 0.
- Reset/clear mid-operation:
  - iclr with ocount = 3: next cycle oempty = 1, ocount = 0, oovf = 0, odata held.
  - iresetn low: odata = 0.
